// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit producing the HI/LO pair.
// A request runs 32 iterations, then one FIN cycle writes hi/lo and pulses done.
module mult_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div0
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN:0]    r_acc;
  logic [XLEN-1:0]  r_q;
  logic [XLEN-1:0]  r_m;
  logic             r_qm1;
  logic             r_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             w_div0;
  logic             w_load;
  logic [XLEN:0]    w_m_ext;
  logic [XLEN:0]    w_sum;
  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_trial;
  logic [XLEN-1:0]  w_a_mag;
  logic [XLEN-1:0]  w_b_mag;
  logic [XLEN-1:0]  w_q_fix;
  logic [XLEN-1:0]  w_r_fix;

  // One Booth add/subtract step, one restoring trial subtract, and the final sign fix-ups.
  // The Booth accumulator is one bit wider so -2^31 operands cannot overflow it.
  always_comb begin
    w_m_ext = {r_m[XLEN-1], r_m};
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + w_m_ext;
      2'b10:   w_sum = r_acc - w_m_ext;
      default: w_sum = r_acc;
    endcase
    w_shift = {r_acc[XLEN-1:0], r_q[XLEN-1]};
    w_trial = w_shift - {1'b0, r_m};
    w_a_mag = a[XLEN-1] ? -a : a;
    w_b_mag = b[XLEN-1] ? -b : b;
    w_q_fix = r_neg_q ? -r_q : r_q;
    w_r_fix = r_neg_r ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  end

  // Next-state logic; a divide by zero is rejected in IDLE and only raises div0.
  always_comb begin
    w_next = r_state;
    w_div0 = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op && (b == {XLEN{1'b0}})) begin
            w_div0 = 1'b1;
          end else begin
            w_load = 1'b1;
            w_next = op ? S_DIV : S_MULT;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MULT, S_DIV: begin
        if (r_cnt == LAST_CNT) begin
          w_next = S_FIN;
        end else begin
          w_next = r_state;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand latch and iteration datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_acc   <= {(XLEN+1){1'b0}};
      r_q     <= {XLEN{1'b0}};
      r_m     <= {XLEN{1'b0}};
      r_qm1   <= 1'b0;
      r_op    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_load) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_acc   <= {(XLEN+1){1'b0}};
      r_qm1   <= 1'b0;
      r_op    <= op;
      r_neg_q <= a[XLEN-1] ^ b[XLEN-1];
      r_neg_r <= a[XLEN-1];
      r_q     <= op ? w_a_mag : b;
      r_m     <= op ? w_b_mag : a;
    end else if (r_state == S_MULT) begin
      r_acc <= {w_sum[XLEN], w_sum[XLEN:1]};
      r_q   <= {w_sum[0], r_q[XLEN-1:1]};
      r_qm1 <= r_q[0];
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == S_DIV) begin
      if (!w_trial[XLEN]) begin
        r_acc <= w_trial;
        r_q   <= {r_q[XLEN-2:0], 1'b1};
      end else begin
        r_acc <= w_shift;
        r_q   <= {r_q[XLEN-2:0], 1'b0};
      end
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Registered outputs; hi/lo only change in the FIN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= {XLEN{1'b0}};
      lo   <= {XLEN{1'b0}};
      busy <= 1'b0;
      done <= 1'b0;
      div0 <= 1'b0;
    end else begin
      busy <= (w_next != S_IDLE);
      done <= (r_state == S_FIN);
      div0 <= w_div0;
      if (r_state == S_FIN) begin
        if (r_op) begin
          hi <= w_r_fix;
          lo <= w_q_fix;
        end else begin
          hi <= r_acc[XLEN-1:0];
          lo <= r_q;
        end
      end
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for the MIPS-subset CPU.
- It consumes A/B register values and produces the HI/LO pair.
- It is sequenced by the control unit through Div_Mult_Ctrl and reports DIV0.
- Its done pulse drives the shared HI/LO write enable.
- It sits between the A/B operand registers and the HI/LO registers.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  Div_Mult_Ctrl; one-cycle request pulse, sampled on a rising edge.
- op  input  1  0 = MULT, 1 = DIV; sampled with start.
- a  input  XLEN  multiplicand / dividend (A_out).
- b  input  XLEN  multiplier / divisor (B_out).
- hi  output  XLEN  MULT: upper product; DIV: remainder.
- lo  output  XLEN  MULT: lower product; DIV: quotient.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when hi/lo are updated; this is the HI/LO write enable.
- div0  output  1  one-cycle pulse on divide by zero.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; hi=0, lo=0, busy=0, done=0, div0=0; counter and internal datapath cleared.
- A reset asserted mid-operation aborts the operation immediately; no done is produced.

States:
- IDLE: waiting for a request.
- MULT: multiply iterations.
- DIV: divide iterations.
- FIN: write results.

IDLE:
- On the edge where start=1, latch a, b and op; counter=0.
- DIV with b=0: stay IDLE, pulse div0 for exactly one cycle after that edge; hi/lo unchanged; no done.
- Otherwise: go to MULT or DIV and set busy=1 from that edge.

Accepting requests:
- start is ignored while busy=1; the latched operands are not disturbed.
- a and b may change freely after the start edge.

MULT:
- Radix-2 Booth algorithm on the signed latched operands.
- One iteration per cycle, 32 iterations (counter 0..31); then go to FIN.
- The 64-bit accumulator is kept internally; hi/lo do not change during iteration.

DIV:
- Restoring division on the operand magnitudes.
- One quotient bit per cycle, 32 iterations; then go to FIN.
- Sign correction is applied in FIN:
  - Quotient is negated if the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF wraps: lo=0x80000000, hi=0.

FIN (one cycle):
- Register hi/lo with the final result.
- done=1 for this single cycle; busy=0 from the next edge; return to IDLE.

Latency:
- Start sampled at edge 0; iterations occupy edges 1..32.
- hi/lo are updated and done rises at edge 33; done is low again after edge 34.
- busy is high from edge 0 to edge 33, then low.
- A new start is accepted on edge 34 at the earliest.
- Start asserted during the FIN cycle is ignored.

Output rules:
- hi/lo hold their last result until the next completed operation.
- done and div0 are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. MULT 7 × −3 (a=0x00000007, b=0xFFFFFFFD) -> done 33 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly those 33 cycles.
2. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000; then MULT 0x0001_0000 × 0x0001_0000 issued on the first allowed edge -> hi=0x00000001, lo=0x00000000.
3. DIV −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7 / −2 -> lo=0xFFFFFFFD, hi=0x00000001; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIV 5 / 0 with prior hi/lo=0x12345678/0x9ABCDEF0 -> div0 high for one cycle after the start edge, busy never rises, no done, hi/lo unchanged.
5. Start MULT 3×4, then pulse start with DIV 9/3 at cycle 10 and change a/b -> second request ignored; result hi=0, lo=12 at edge 33; exactly one done pulse.
6. Start DIV 100/7, assert reset low at cycle 15 for 2 cycles -> hi=lo=0, busy=0 immediately; no done; a subsequent DIV 100/7 -> lo=14, hi=2.
